// File: rtl/obf_lut_prog.sv
// Programmable multi-bank substitution LUT: pointer table (index -> base) feeding a data table
// that yields the substitution and immediate words, behind a 2-stage valid/ready pipeline.
module obf_lut_prog #(
  parameter int IDX_WIDTH  = 7,
  parameter int PPC_WIDTH  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [BANK_W-1:0]     cfg_bank,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [OUT_WIDTH-1:0]  cfg_wdata,
  input  logic                  cfg_lock,
  output logic                  cfg_err,
  output logic                  locked,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_WIDTH-1:0]  req_index,
  input  logic [PPC_WIDTH-1:0]  req_ppc,
  input  logic [BANK_W-1:0]     req_key,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [OUT_WIDTH-1:0]  out_sub,
  output logic [OUT_WIDTH-1:0]  out_imm,
  output logic                  out_hit
);
  localparam int PTR_AW  = BANK_W + IDX_WIDTH;
  localparam int DATA_AW = BANK_W + ADDR_WIDTH;

  // Tables are flattened as {bank, address}; only the valid bits are reset.
  logic [ADDR_WIDTH-1:0] ptr_base_mem [2**PTR_AW];
  logic [2**PTR_AW-1:0]  ptr_valid_reg;
  logic [OUT_WIDTH-1:0]  data_mem [2**DATA_AW];

  logic                  cfg_bank_ok, cfg_accept, ptr_wr, data_wr;
  logic [PTR_AW-1:0]     ptr_waddr;
  logic [DATA_AW-1:0]    data_waddr;

  assign cfg_bank_ok = 32'(cfg_bank) < 32'(NUM_BANKS);
  assign cfg_accept  = cfg_we && !locked && cfg_bank_ok;
  assign ptr_wr      = cfg_accept && cfg_sel;
  assign data_wr     = cfg_accept && !cfg_sel;
  assign ptr_waddr   = {cfg_bank, cfg_addr[IDX_WIDTH-1:0]};
  assign data_waddr  = {cfg_bank, cfg_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked        <= 1'b0;
      cfg_err       <= 1'b0;
      ptr_valid_reg <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_accept;
      if (cfg_lock) locked <= 1'b1;
      if (ptr_wr) ptr_valid_reg[ptr_waddr] <= cfg_wdata[ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (ptr_wr)  ptr_base_mem[ptr_waddr] <= cfg_wdata[ADDR_WIDTH-1:0];
    if (data_wr) data_mem[data_waddr]    <= cfg_wdata;
  end

  // Stage 1 lookup: out-of-range keys fall back to the bank-0 default entry.
  logic                  key_ok, look_hit;
  logic [BANK_W-1:0]     look_bank;
  logic [PTR_AW-1:0]     look_ptr;
  logic [ADDR_WIDTH-1:0] look_base, look_addr;

  assign key_ok    = 32'(req_key) < 32'(NUM_BANKS);
  assign look_bank = key_ok ? req_key : '0;
  assign look_ptr  = {look_bank, req_index};
  assign look_hit  = key_ok && ptr_valid_reg[look_ptr];
  assign look_base = look_hit ? ptr_base_mem[look_ptr] : '0;
  assign look_addr = look_base + ADDR_WIDTH'(req_ppc);

  logic                  s1_v_reg, s1_hit_reg;
  logic [BANK_W-1:0]     s1_bank_reg;
  logic [ADDR_WIDTH-1:0] s1_addr_reg, s1_addr_inc;
  logic                  s2_free;

  assign s1_addr_inc = s1_addr_reg + ADDR_WIDTH'(1);
  assign s2_free     = !resp_valid || resp_ready;
  assign req_ready   = !s1_v_reg || s2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg    <= 1'b0;
      s1_hit_reg  <= 1'b0;
      s1_bank_reg <= '0;
      s1_addr_reg <= '0;
      resp_valid  <= 1'b0;
      out_sub     <= '0;
      out_imm     <= '0;
      out_hit     <= 1'b0;
    end else begin
      if (s2_free) begin
        resp_valid <= s1_v_reg;
        if (s1_v_reg) begin
          out_sub <= data_mem[{s1_bank_reg, s1_addr_reg}];
          out_imm <= data_mem[{s1_bank_reg, s1_addr_inc}];
          out_hit <= s1_hit_reg;
        end
      end
      if (req_ready) begin
        s1_v_reg <= req_valid;
        if (req_valid) begin
          s1_hit_reg  <= look_hit;
          s1_bank_reg <= look_bank;
          s1_addr_reg <= look_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_obf_lut_prog.sv
// Self-checking bench for obf_lut_prog against an array-based model of the pointer/data tables.
module tb_obf_lut_prog;
  localparam int IDX_WIDTH = 7, PPC_WIDTH = 4, ADDR_WIDTH = 8, OUT_WIDTH = 16;
  localparam int NUM_BANKS = 2, BANK_W = 1, DEPTH = 256, NIDX = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 0, cfg_sel = 0, cfg_lock = 0, cfg_err, locked;
  logic [BANK_W-1:0] cfg_bank = '0;
  logic [ADDR_WIDTH-1:0] cfg_addr = '0;
  logic [OUT_WIDTH-1:0] cfg_wdata = '0;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 0, out_hit;
  logic [IDX_WIDTH-1:0] req_index = '0;
  logic [PPC_WIDTH-1:0] req_ppc = '0;
  logic [BANK_W-1:0] req_key = '0;
  logic [OUT_WIDTH-1:0] out_sub, out_imm;

  always #5 clk = ~clk;

  obf_lut_prog dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_bank(cfg_bank),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_lock(cfg_lock), .cfg_err(cfg_err),
    .locked(locked), .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_ppc(req_ppc), .req_key(req_key), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .out_sub(out_sub), .out_imm(out_imm), .out_hit(out_hit)
  );

  typedef struct packed {
    logic hit;
    logic [OUT_WIDTH-1:0] sub;
    logic [OUT_WIDTH-1:0] imm;
  } resp_t;

  logic [OUT_WIDTH-1:0] m_data [NUM_BANKS][DEPTH];
  bit m_pv [NUM_BANKS][NIDX];
  int m_pb [NUM_BANKS][NIDX];
  bit m_locked = 0;
  resp_t exp_q[$];
  int checks = 0, failures = 0;

  function automatic resp_t model_lookup(int idx, int ppc, int key);
    resp_t r;
    int bank, base, a;
    bank = (key < NUM_BANKS) ? key : 0;
    r.hit = (key < NUM_BANKS) && m_pv[bank][idx];
    base = r.hit ? m_pb[bank][idx] : 0;
    a = (base + ppc) % DEPTH;
    r.sub = m_data[bank][a];
    r.imm = m_data[bank][(a + 1) % DEPTH];
    return r;
  endfunction

  task automatic cfg_write(input bit sel, input int bank, input int addr, input int wdata, input bit lock);
    @(negedge clk);
    cfg_we = 1; cfg_sel = sel; cfg_bank = bank[BANK_W-1:0]; cfg_addr = addr[ADDR_WIDTH-1:0];
    cfg_wdata = wdata[OUT_WIDTH-1:0]; cfg_lock = lock;
    @(negedge clk);
    cfg_we = 0; cfg_lock = 0;
    if (!m_locked && bank < NUM_BANKS) begin
      if (sel) begin
        m_pv[bank][addr % NIDX] = wdata[ADDR_WIDTH];
        m_pb[bank][addr % NIDX] = wdata % DEPTH;
      end else begin
        m_data[bank][addr] = wdata[OUT_WIDTH-1:0];
      end
    end
    if (lock) m_locked = 1;
  endtask

  task automatic single_lookup(input string name, input int idx, input int ppc, input int key, output resp_t got);
    resp_t e;
    int lat;
    e = model_lookup(idx, ppc, key);
    @(negedge clk);
    req_valid = 1; req_index = idx[IDX_WIDTH-1:0]; req_ppc = ppc[PPC_WIDTH-1:0];
    req_key = key[BANK_W-1:0]; resp_ready = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_ready: got %b want 1", name, req_ready); end
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
    got = {out_hit, out_sub, out_imm};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s_data: got hit=%b sub=%h imm=%h want hit=%b sub=%h imm=%h",
               name, got.hit, got.sub, got.imm, e.hit, e.sub, e.imm);
    end
    $display("lookup %s idx=%0d ppc=%0d key=%0d -> hit=%b sub=%h imm=%h", name, idx, ppc, key, got.hit, got.sub, got.imm);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, locked, cfg_err, out_hit, out_sub, out_imm} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rv=%b lk=%b err=%b hit=%b sub=%h imm=%h want all 0",
               resp_valid, locked, cfg_err, out_hit, out_sub, out_imm);
    end
    rst_n = 1;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int a = 0; a < DEPTH; a++) cfg_write(0, b, a, int'($urandom_range(0, 65535)), 0);
    $display("reset and data preload done");
  endtask

  task automatic test_default_miss();
    resp_t got;
    single_lookup("default_miss", 27, 0, 0, got);
    checks++;
    if (got.hit !== 1'b0) begin failures++; $display("FAIL default_miss_hit: got %b want 0", got.hit); end
  endtask

  task automatic test_program();
    resp_t got;
    cfg_write(1, 0, 27, (1 << 8) | 6, 0);
    cfg_write(0, 0, 6, 16'h54BD, 0);
    cfg_write(0, 0, 7, 16'h5400, 0);
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL program_err: got %b want 0", cfg_err); end
    single_lookup("program", 27, 0, 0, got);
    checks++;
    if (got !== {1'b1, 16'h54BD, 16'h5400}) begin
      failures++; $display("FAIL program_const: got %h want 154bd5400", got);
    end
  endtask

  task automatic test_wrap();
    resp_t got;
    cfg_write(1, 1, 5, (1 << 8) | 8'hFE, 0);
    single_lookup("wrap", 5, 1, 1, got);
    single_lookup("wrap_ppc15", 5, 15, 1, got);
  endtask

  task automatic test_back_to_back(input string name, input int cycles, input int stall_start);
    int acc = 0, dlv = 0, idx;
    bit prev_stall = 0, exp_ready;
    resp_t prev_out = '0, e, cur;
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, NIDX - 1);
      if (idx == 27 || idx == 40) idx = 1;
      cfg_write(1, $urandom_range(0, NUM_BANKS - 1), idx, $urandom_range(0, 511), 0);
    end
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      if (c >= stall_start - 2 && c < stall_start + 3) req_valid = 1;
      else req_valid = (c < cycles) && ($urandom_range(0, 3) != 0);
      req_index = IDX_WIDTH'($urandom_range(0, NIDX - 1));
      req_ppc = PPC_WIDTH'($urandom_range(0, 15));
      req_key = BANK_W'($urandom_range(0, NUM_BANKS - 1));
      resp_ready = (c >= stall_start && c < stall_start + 3) ? 1'b0 : ($urandom_range(0, 4) != 0);
      #1;
      cur = {out_hit, out_sub, out_imm};
      exp_ready = (exp_q.size() < 2) || resp_ready;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL %s_req_ready c=%0d: got %b want %b", name, c, req_ready, exp_ready);
      end
      if (prev_stall) begin
        checks++;
        if (resp_valid !== 1'b1 || cur !== prev_out) begin
          failures++; $display("FAIL %s_hold c=%0d: got rv=%b %h want rv=1 %h", name, c, resp_valid, cur, prev_out);
        end
      end
      if (exp_q.size() == 2) begin
        checks++;
        if (resp_valid !== 1'b1) begin failures++; $display("FAIL %s_full_valid c=%0d: got %b want 1", name, c, resp_valid); end
      end
      if (resp_valid === 1'b1 && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL %s_spurious c=%0d: got response %h want none", name, c, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++; $display("FAIL %s_resp c=%0d: got %h want %h", name, c, cur, e);
          end
          $display("%s deliver #%0d hit=%b sub=%h imm=%h", name, dlv, cur.hit, cur.sub, cur.imm);
        end
        dlv++;
      end
      if (req_valid && req_ready === 1'b1) begin
        exp_q.push_back(model_lookup(int'(req_index), int'(req_ppc), int'(req_key)));
        acc++;
      end
      prev_stall = (resp_valid === 1'b1) && !resp_ready;
      prev_out = cur;
    end
    @(negedge clk);
    req_valid = 0; resp_ready = 1;
    checks++;
    if (exp_q.size() != 0 || acc != dlv) begin
      failures++; $display("FAIL %s_count: got delivered=%0d want %0d", name, dlv, acc);
    end
    exp_q.delete();
  endtask

  task automatic test_lock();
    resp_t got;
    cfg_write(1, 0, 40, (1 << 8) | 90, 1);
    checks++;
    if (cfg_err !== 1'b0 || locked !== 1'b1) begin
      failures++; $display("FAIL lock_set: got err=%b locked=%b want err=0 locked=1", cfg_err, locked);
    end
    cfg_write(0, 0, 6, 16'hFFFF, 0);
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL lock_err_pulse: got %b want 1", cfg_err); end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL lock_err_once: got %b want 0", cfg_err); end
    single_lookup("locked_read", 27, 0, 0, got);
    checks++;
    if (got.sub !== 16'h54BD) begin failures++; $display("FAIL locked_sub: got %h want 54bd", got.sub); end
    single_lookup("write_with_lock", 40, 0, 0, got);
  endtask

  task automatic test_reset_inflight();
    resp_t got;
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_index = 7'd27; req_ppc = '0; req_key = '0;
    @(negedge clk);
    req_index = 7'd40;
    @(negedge clk);
    req_valid = 0;
    rst_n = 0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || locked !== 1'b0) begin
      failures++; $display("FAIL rst_inflight: got rv=%b locked=%b want 0 0", resp_valid, locked);
    end
    m_locked = 0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int i = 0; i < NIDX; i++) m_pv[b][i] = 0;
    @(negedge clk);
    rst_n = 1; resp_ready = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_residue: got rv=%b want 0", resp_valid); end
    single_lookup("after_reset", 27, 0, 0, got);
    checks++;
    if (got.hit !== 1'b0) begin failures++; $display("FAIL after_reset_hit: got %b want 0", got.hit); end
  endtask

  initial begin
    test_reset();
    test_default_miss();
    test_program();
    test_wrap();
    test_back_to_back("stream", 200, 30);
    test_lock();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
